// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared constants for the instruction-memory responder.
//   INST_W / ADDR_W    : instruction and address widths
//   DEFAULT_BASE_ADDR  : byte address of memory word 0
//   ERR_INST           : instruction word returned on a faulting fetch
//   is_misaligned()    : word-alignment check on the two address LSBs
// ---------------------------------------------------------------------------
package imem_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
  localparam logic [INST_W-1:0] ERR_INST          = 32'h0000_0000;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/imem_resp_if.sv
// ---------------------------------------------------------------------------
// imem_resp_if
// Fetch request / instruction response bundle.
//   req_valid, req_addr   : request from the fetch unit (master drives)
//   req_ready             : responder can accept (slave drives)
//   resp_valid, resp_inst,
//   resp_err              : in-order response (slave drives)
//   resp_ready            : consumer accepts response (master drives)
// ---------------------------------------------------------------------------
interface imem_resp_if;
  import imem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [INST_W-1:0] resp_inst;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_inst, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_inst, resp_err
  );

endinterface

// File: rtl/imem_resp_fifo.sv
// ---------------------------------------------------------------------------
// resp_fifo
// Synchronous circular-buffer FIFO with a registered head entry.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data (accepted when not full, or when popping)
//   push_data  : entry to write
//   pop        : remove the head entry (ignored when empty)
//   head_data  : registered copy of the current head entry (0 when empty)
//   full/empty : occupancy flags derived from wrap-bit pointers
//   count      : number of stored entries
// ---------------------------------------------------------------------------
module resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] buf_r [DEPTH];
  logic [WIDTH-1:0] head_r;
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      wr_ptr_next_s;
  logic [AW:0]      rd_ptr_next_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count     = wr_ptr_r - rd_ptr_r;
  assign head_data = head_r;

  // Qualified push/pop and next pointer values.
  always_comb begin
    do_pop_s      = pop & ~empty;
    // When full, a simultaneous pop frees the slot being written.
    do_push_s     = push & (~full | do_pop_s);
    rd_ptr_next_s = rd_ptr_r + (AW+1)'(do_pop_s);
    wr_ptr_next_s = wr_ptr_r + (AW+1)'(do_push_s);
  end

  // Entry storage; contents need no reset, occupancy is tracked by pointers.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      buf_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

  // Pointers and registered head entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      head_r   <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      if (rd_ptr_next_s == wr_ptr_next_s) begin
        head_r <= '0;
      end else if (do_push_s && (rd_ptr_next_s == wr_ptr_r)) begin
        // The entry written this cycle becomes the new head.
        head_r <= push_data;
      end else begin
        head_r <= buf_r[rd_ptr_next_s[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/imem_resp.sv
// ---------------------------------------------------------------------------
// imem_resp
// Instruction-memory responder. Fetch requests are accepted over a
// valid/ready handshake, the word is read one cycle later, delayed to a
// fixed LATENCY, and queued in an in-order response FIFO. A request is only
// accepted when a FIFO slot is guaranteed for it (credit rule), so the
// pipeline never stalls and no response is dropped.
//   clk, rst  : clock, synchronous active-high reset (memory is kept)
//   bus       : imem_resp_if slave (req_* in, resp_* out)
//   ld_en     : preload write enable
//   ld_idx    : preload word index
//   ld_data   : preload word
// ---------------------------------------------------------------------------
module imem_resp
  import imem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int                DEPTH      = 1024,
  parameter int                LATENCY    = 2,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  imem_resp_if.slave               bus,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [INST_W-1:0]        ld_data
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] SPAN    = ADDR_W'(DEPTH * 4);
  localparam logic [31:0]       CREDITS = 32'(FIFO_DEPTH);

  logic [INST_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0]  off_s;
  logic [IDX_W-1:0]   word_idx_s;
  logic               err_s;
  logic               ready_s;
  logic               accept_s;
  logic [31:0]        used_s;

  logic [LATENCY-1:0] pipe_valid_r;
  logic [LATENCY-1:0] pipe_err_r;
  logic [INST_W-1:0]  pipe_inst_r [LATENCY];

  logic [INST_W:0]    push_data_s;
  logic [INST_W:0]    head_s;
  logic               pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CNT_W-1:0]   fifo_count_s;

  // Address decode: offset from base wraps for addresses below BASE_ADDR,
  // so a single unsigned compare catches both ends of the window.
  always_comb begin
    off_s      = bus.req_addr - BASE_ADDR;
    word_idx_s = off_s[IDX_W+1:2];
    err_s      = is_misaligned(bus.req_addr[1:0]) || (off_s >= SPAN);
  end

  // Credit check: every in-flight stage and every queued entry holds a slot.
  // Built only from registers, so a pop frees its credit one cycle later.
  always_comb begin
    used_s = 32'(fifo_count_s);
    for (int i = 0; i < LATENCY; i++) begin
      used_s = used_s + 32'(pipe_valid_r[i]);
    end
    ready_s  = ~rst & ~fifo_full_s & (used_s < CREDITS);
    accept_s = bus.req_valid & ready_s;
  end

  assign bus.req_ready = ready_s;

  // Preload write port; deliberately independent of rst.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
  end

  // Pipeline valid bits, cleared by reset to drop in-flight fetches.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_r <= '0;
    end else begin
      pipe_valid_r[0] <= accept_s;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
      end
    end
  end

  // Pipeline data: stage 0 reads memory at acceptance. The preload write is
  // non-blocking on the same edge, so a same-cycle fetch sees the old word.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      pipe_inst_r[0] <= mem[word_idx_s];
      pipe_err_r[0]  <= err_s;
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_inst_r[i] <= pipe_inst_r[i-1];
      pipe_err_r[i]  <= pipe_err_r[i-1];
    end
  end

  // Faulting fetches carry the error word instead of memory data.
  always_comb begin
    if (pipe_err_r[LATENCY-1]) begin
      push_data_s = {1'b1, ERR_INST};
    end else begin
      push_data_s = {1'b0, pipe_inst_r[LATENCY-1]};
    end
  end

  assign pop_s = ~fifo_empty_s & bus.resp_ready;

  resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INST_W + 1)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_valid_r[LATENCY-1]),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head_data (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign bus.resp_valid = ~fifo_empty_s;
  assign bus.resp_err   = head_s[INST_W];
  assign bus.resp_inst  = head_s[INST_W-1:0];

endmodule

// File: tb/tb_imem_resp.sv
// ---------------------------------------------------------------------------
// tb_imem_resp
// Self-checking bench for imem_resp. A reference model (word array plus a
// queue of outstanding fetches tagged with their acceptance edge) predicts
// req_ready, resp_valid and the response contents every cycle; table vectors
// and hand-written sequences cover the multi-cycle corner cases.
// ---------------------------------------------------------------------------
module tb_imem_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          LAT  = 2;
  localparam int          FD   = 4;
  localparam int          WDS  = 1024;

  typedef struct {
    logic        err;
    logic [31:0] inst;
    int          acc_edge;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        err;
    logic [31:0] inst;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [9:0]  ld_idx;
  logic [31:0] ld_data;

  imem_resp_if bus ();

  imem_resp dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ld_en   (ld_en),
    .ld_idx  (ld_idx),
    .ld_data (ld_data)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case something wedges the stimulus.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  exp_t        q[$];
  logic [31:0] ref_mem [WDS];
  int          edge_cnt = 0;
  int          tests = 0;
  int          fails = 0;
  bit          last_acc;
  bit          last_pop;
  logic [31:0] last_pop_inst;
  logic        last_pop_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Fetch outcome straight from the address rules.
  function automatic exp_t model_fetch(input logic [31:0] addr);
    exp_t        e;
    longint      off;
    logic [31:0] widx;
    off  = longint'(addr) - longint'(BASE);
    e.err = (addr % 4 != 0) || (off < 0) || (off >= WDS * 4);
    widx = 32'(off / 4);
    e.inst = e.err ? 32'h0 : ref_mem[widx[9:0]];
    e.acc_edge = 0;
    return e;
  endfunction

  // One clock cycle: check outputs against the model, then advance the model
  // by what the coming edge does, and wait for the next falling edge.
  task automatic tick();
    bit   exp_ready;
    bit   exp_valid;
    exp_t e;
    #1;
    exp_ready = !rst && (q.size() < FD);
    exp_valid = (q.size() > 0) && (q[0].acc_edge + LAT <= edge_cnt);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("resp_valid", 32'(bus.resp_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("resp_inst", bus.resp_inst, q[0].inst);
      chk("resp_err", 32'(bus.resp_err), 32'(q[0].err));
    end
    last_acc = 1'b0;
    last_pop = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      if (exp_valid && bus.resp_ready) begin
        last_pop      = 1'b1;
        last_pop_inst = bus.resp_inst;
        last_pop_err  = bus.resp_err;
        void'(q.pop_front());
      end
      if (bus.req_valid && exp_ready) begin
        e = model_fetch(bus.req_addr);
        e.acc_edge = edge_cnt + 1;
        q.push_back(e);
        last_acc = 1'b1;
      end
    end
    if (ld_en) ref_mem[ld_idx] = ld_data;
    edge_cnt++;
    @(negedge clk);
  endtask

  // Single fetch with an otherwise idle pipeline.
  task automatic fetch_one(input logic [31:0] addr, output logic [31:0] inst, output logic err);
    bit acc = 1'b0;
    bit got = 1'b0;
    inst = 32'hx;
    err  = 1'bx;
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) begin
        acc = 1'b1;
        break;
      end
    end
    bus.req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!acc) break;
      tick();
      if (last_pop) begin
        got  = 1'b1;
        inst = last_pop_inst;
        err  = last_pop_err;
        break;
      end
    end
    chk("fetch_done", 32'(acc && got), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    logic [31:0] a;
    k = $urandom_range(0, 9);
    case (k)
      6:       a = BASE + 32'($urandom_range(0, WDS - 1)) * 32'd4 + 32'($urandom_range(1, 3));
      7:       a = BASE + 32'd4096 + 32'($urandom_range(0, 255)) * 32'd4;
      8:       a = BASE - 32'($urandom_range(1, 16)) * 32'd4;
      9:       a = $urandom;
      default: a = BASE + 32'($urandom_range(0, WDS - 1)) * 32'd4;
    endcase
    return a;
  endfunction

  vec_t        vt[9];
  logic [31:0] r_inst;
  logic        r_err;
  int          n_acc;
  int          n_pop;
  int          first_acc;
  int          last_acc_edge;
  int          pop_edge[8];
  logic [31:0] pop_val[8];
  logic [31:0] held_inst;
  bit          have_held;
  bit          hold;

  // Main stimulus.
  initial begin
    vt[0] = '{32'h8000_0002, 1'b1, 32'h0000_0000};
    vt[1] = '{32'h8000_1000, 1'b1, 32'h0000_0000};
    vt[2] = '{32'h7FFF_FFFC, 1'b1, 32'h0000_0000};
    vt[3] = '{32'h8000_0FFC, 1'b0, 32'hCAFE_F00D};
    vt[4] = '{32'h8000_0000, 1'b0, 32'h0000_0001};
    vt[5] = '{32'h8000_001C, 1'b0, 32'h0000_0008};
    vt[6] = '{32'hFFFF_FFFC, 1'b1, 32'h0000_0000};
    vt[7] = '{32'h8000_0FFF, 1'b1, 32'h0000_0000};
    vt[8] = '{32'h0000_0000, 1'b1, 32'h0000_0000};

    rst            = 1'b1;
    ld_en          = 1'b0;
    ld_idx         = 10'd0;
    ld_data        = 32'd0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'd0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_inst", bus.resp_inst, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Preload the whole array through the load port.
    ld_en = 1'b1;
    for (int i = 0; i < WDS; i++) begin
      ld_idx  = 10'(i);
      ld_data = (i < 8) ? 32'(i + 1) : ((i == WDS - 1) ? 32'hCAFE_F00D : $urandom);
      tick();
    end
    ld_en = 1'b0;

    // Table vectors: address checks and plain reads.
    for (int i = 0; i < 9; i++) begin
      fetch_one(vt[i].addr, r_inst, r_err);
      chk($sformatf("vec%0d_err", i), 32'(r_err), 32'(vt[i].err));
      chk($sformatf("vec%0d_inst", i), r_inst, vt[i].inst);
    end

    // Back-to-back fetches with the consumer always ready.
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_addr   = BASE;
    n_acc = 0; n_pop = 0; first_acc = -1; last_acc_edge = -1;
    for (int c = 0; c < 40 && n_pop < 8; c++) begin
      tick();
      if (last_acc) begin
        if (first_acc < 0) first_acc = edge_cnt;
        last_acc_edge = edge_cnt;
        n_acc++;
        if (n_acc < 8) bus.req_addr = BASE + 32'(n_acc * 4);
        else bus.req_valid = 1'b0;
      end
      if (last_pop && n_pop < 8) begin
        pop_val[n_pop]  = last_pop_inst;
        pop_edge[n_pop] = edge_cnt;
        n_pop++;
      end
    end
    chk("bp_pops", 32'(n_pop), 32'd8);
    chk("bp_accept_span", 32'(last_acc_edge - first_acc), 32'd7);
    chk("bp_first_latency", 32'(pop_edge[0] - first_acc), 32'(LAT + 1));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_data%0d", i), pop_val[i], 32'(i + 1));
      if (i > 0) chk($sformatf("bp_gap%0d", i), 32'(pop_edge[i] - pop_edge[i-1]), 32'd1);
    end

    // FIFO fill under backpressure, with stall-hold checking.
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = BASE;
    n_acc = 0; have_held = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (last_acc) begin
        n_acc++;
        bus.req_addr = BASE + 32'(n_acc * 4);
      end
      if (bus.resp_valid) begin
        if (!have_held) begin
          held_inst = bus.resp_inst;
          have_held = 1'b1;
        end else begin
          chk("stall_hold_inst", bus.resp_inst, held_inst);
          chk("stall_hold_err", 32'(bus.resp_err), 32'd0);
        end
      end
    end
    chk("fill_accepts", 32'(n_acc), 32'(FD));
    chk("fill_ready_low", 32'(bus.req_ready), 32'd0);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    n_pop = 0;
    for (int c = 0; c < 20 && n_pop < 4; c++) begin
      tick();
      if (last_pop) begin
        chk($sformatf("fill_data%0d", n_pop), last_pop_inst, 32'(n_pop + 1));
        n_pop++;
        if (n_pop == 1) chk("fill_credit_return", 32'(bus.req_ready), 32'd1);
      end
    end
    chk("fill_pops", 32'(n_pop), 32'd4);

    // Read-first: preload and fetch of the same word on one edge.
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h8000_000C;
    ld_en          = 1'b1;
    ld_idx         = 10'd3;
    ld_data        = 32'hDEAD_BEEF;
    tick();
    chk("rf_accept", 32'(last_acc), 32'd1);
    ld_en         = 1'b0;
    bus.req_valid = 1'b0;
    n_pop = 0;
    for (int c = 0; c < 20 && n_pop == 0; c++) begin
      tick();
      if (last_pop) begin
        n_pop++;
        chk("rf_old_word", last_pop_inst, 32'h0000_0004);
      end
    end
    chk("rf_pop", 32'(n_pop), 32'd1);
    fetch_one(32'h8000_000C, r_inst, r_err);
    chk("rf_new_word", r_inst, 32'hDEAD_BEEF);

    // Reset with three fetches outstanding; preload during reset.
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = BASE + 32'h20;
    n_acc = 0;
    for (int c = 0; c < 10 && n_acc < 3; c++) begin
      tick();
      if (last_acc) begin
        n_acc++;
        bus.req_addr = BASE + 32'h20 + 32'(n_acc * 4);
      end
    end
    chk("rst_mid_accepts", 32'(n_acc), 32'd3);
    bus.req_valid = 1'b0;
    rst     = 1'b1;
    ld_en   = 1'b1;
    ld_idx  = 10'd9;
    ld_data = 32'h1234_5678;
    tick();
    rst   = 1'b0;
    ld_en = 1'b0;
    bus.resp_ready = 1'b1;
    n_pop = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.resp_valid) n_pop++;
    end
    chk("rst_mid_no_resp", 32'(n_pop), 32'd0);
    fetch_one(32'h8000_0014, r_inst, r_err);
    chk("rst_mem_kept", r_inst, 32'h0000_0006);
    fetch_one(32'h8000_0024, r_inst, r_err);
    chk("rst_ld_during_rst", r_inst, 32'h1234_5678);

    // Randomised traffic against the model.
    hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        bus.req_valid = ($urandom_range(0, 3) != 0);
        bus.req_addr  = rand_addr();
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      ld_en   = ($urandom_range(0, 15) == 0);
      ld_idx  = ($urandom_range(0, 1) == 1) ? bus.req_addr[11:2] : 10'($urandom);
      ld_data = $urandom;
      rst     = ($urandom_range(0, 199) == 0);
      tick();
      hold = bus.req_valid && !last_acc;
    end
    rst            = 1'b0;
    ld_en          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 30 && q.size() > 0; c++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
